// File: rtl/print_tx.sv
// print_tx: formats a 32-bit word as a raw byte or 8 uppercase hex digits and streams the bytes over valid/ready
// Ports: clk, rst (async, active-high); dout_tx/type_tx sampled on a req_tx rising edge in IDLE;
//        d_tx/vld_tx/rdy_tx byte handshake toward the serializer; ack_tx pulses once after the last byte.
// Option: define PRINT_CRLF_EN to append 0x0D 0x0A to hex prints.
module print_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dout_tx,
  input  logic        type_tx,
  input  logic        req_tx,
  output logic        ack_tx,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef PRINT_CRLF_EN
  localparam logic [3:0] HEX_LAST = 4'd9;
`else
  localparam logic [3:0] HEX_LAST = 4'd7;
`endif
  logic [1:0]  r_state;
  logic        r_req_q;
  logic        r_type;
  logic [31:0] r_sr;
  logic [3:0]  r_cnt;
  logic [3:0]  w_nib;
  logic [7:0]  w_hex;
  logic [7:0]  w_byte;
  logic        w_last;
  logic        w_xfer;
  assign w_nib = r_sr[31:28];
  assign w_hex = w_nib < 4'd10 ? 8'h30 + {4'h0, w_nib} : 8'h37 + {4'h0, w_nib};
`ifdef PRINT_CRLF_EN
  // Counter positions 8 and 9 carry the terminator after the eight digits
  assign w_byte = !r_type ? r_sr[7:0] : r_cnt == 4'd8 ? 8'h0D : r_cnt == 4'd9 ? 8'h0A : w_hex;
`else
  assign w_byte = r_type ? w_hex : r_sr[7:0];
`endif
  assign w_last = !r_type || r_cnt == HEX_LAST;
  assign vld_tx = r_state == S_SEND;
  assign ack_tx = r_state == S_DONE;
  assign w_xfer = vld_tx && rdy_tx;
  // Gate the byte so d_tx reads 0x00 whenever nothing is offered
  assign d_tx   = vld_tx ? w_byte : 8'h00;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req_q <= 1'b0;
      r_type  <= 1'b0;
      r_sr    <= 32'h0;
      r_cnt   <= 4'h0;
    end else begin
      r_req_q <= req_tx;
      if (r_state == S_IDLE && req_tx && !r_req_q) begin
        r_state <= S_SEND;
        r_sr    <= dout_tx;
        r_type  <= type_tx;
        r_cnt   <= 4'h0;
      end else if (r_state == S_SEND && w_xfer) begin
        if (w_last) r_state <= S_DONE;
        else begin
          r_cnt <= r_cnt + 4'h1;
          if (r_type) r_sr <= {r_sr[27:0], 4'h0};
        end
      end else if (r_state == S_DONE) r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_print_tx.sv
// tb_print_tx: directed self-checking bench for print_tx
module tb_print_tx;
`ifdef PRINT_CRLF_EN
  localparam int NH = 10;
`else
  localparam int NH = 8;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dout_tx = 32'h0;
  logic        type_tx = 1'b0;
  logic        req_tx = 1'b0;
  logic        ack_tx;
  logic [7:0]  d_tx;
  logic        vld_tx;
  logic        rdy_tx = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          acks = 0;
  int          hold_bad = 0;
  int          base;
  int          hb;
  logic        p_stall = 1'b0;
  logic [7:0]  p_d = 8'h0;
  logic [7:0]  q[$];
  print_tx dut (
    .clk(clk), .rst(rst), .dout_tx(dout_tx), .type_tx(type_tx), .req_tx(req_tx),
    .ack_tx(ack_tx), .d_tx(d_tx), .vld_tx(vld_tx), .rdy_tx(rdy_tx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (vld_tx && rdy_tx) q.push_back(d_tx);
    if (ack_tx) acks++;
    if (p_stall && (!vld_tx || d_tx !== p_d)) hold_bad++;
    p_stall = vld_tx && !rdy_tx;
    p_d = d_tx;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_bytes(input string tag, input int n, input logic [79:0] e);
    chk({tag, "_count"}, q.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), i < q.size() ? {24'h0, q[i]} : 32'hx, {24'h0, e[79-8*i -: 8]});
    q.delete();
  endtask
  task automatic wait_ack(input string tag, input int budget);
    int k = 0;
    while (acks == base && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_acks"}, acks - base, 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_vld", vld_tx, 0);
    chk("rst_ack", ack_tx, 0);
    chk("rst_d", d_tx, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_vld", vld_tx, 0);
    // raw character, request level held high
    base = acks;
    dout_tx = 32'h31; type_tx = 1'b0; rdy_tx = 1'b1; req_tx = 1'b1;
    @(posedge clk); #1;
    chk("raw_vld", vld_tx, 1);
    chk("raw_d", d_tx, 8'h31);
    @(posedge clk); #1;
    chk("raw_vld_off", vld_tx, 0);
    chk("raw_ack", ack_tx, 1);
    @(posedge clk); #1;
    chk("raw_ack_off", ack_tx, 0);
    repeat (5) @(negedge clk);
    chk("raw_noretrig", acks - base, 1);
    chk_bytes("raw", 1, {8'h31, 72'h0});
    req_tx = 1'b0;
    @(negedge clk);
    // hex digits
    base = acks;
    dout_tx = 32'h31; type_tx = 1'b1; req_tx = 1'b1;
    @(negedge clk); req_tx = 1'b0;
    wait_ack("hex31", 40);
    chk_bytes("hex31", NH, {64'h3030303030303331, 16'h0D0A});
    // hex letters
    base = acks;
    dout_tx = 32'hDEADBEEF; req_tx = 1'b1;
    @(negedge clk); req_tx = 1'b0;
    wait_ack("hexdead", 40);
    chk_bytes("hexdead", NH, {64'h4445414442454546, 16'h0D0A});
    // backpressure with pseudo-random ready
    base = acks; hb = hold_bad;
    dout_tx = 32'h0123ABCD; req_tx = 1'b1; rdy_tx = 1'b0;
    for (int k = 0; k < 300 && acks == base; k++) begin
      @(negedge clk);
      req_tx = 1'b0;
      rdy_tx = 1'($urandom_range(0, 1));
    end
    rdy_tx = 1'b1;
    repeat (4) @(negedge clk);
    chk("bp_acks", acks - base, 1);
    chk("bp_hold", hold_bad - hb, 0);
    chk_bytes("bp", NH, {64'h3031323341424344, 16'h0D0A});
    // second request and input change while busy
    base = acks;
    dout_tx = 32'h89ABCDEF; type_tx = 1'b1; req_tx = 1'b1;
    @(negedge clk); req_tx = 1'b0;
    repeat (2) @(negedge clk);
    req_tx = 1'b1; dout_tx = 32'h11111111; type_tx = 1'b0;
    wait_ack("busy", 40);
    chk_bytes("busy", NH, {64'h3839414243444546, 16'h0D0A});
    req_tx = 1'b0;
    @(negedge clk);
    // reset in the middle of a hex transfer
    dout_tx = 32'hCAFEF00D; type_tx = 1'b1; req_tx = 1'b1;
    @(negedge clk); req_tx = 1'b0;
    for (int k = 0; k < 40 && q.size() < 3; k++) @(negedge clk);
    chk("mid_vld", vld_tx, 1);
    chk("mid_d", d_tx, 8'h45);
    rst = 1'b1; #1;
    chk("mid_rst_vld", vld_tx, 0);
    chk("mid_rst_ack", ack_tx, 0);
    chk("mid_rst_d", d_tx, 0);
    @(negedge clk); rst = 1'b0; q.delete();
    @(negedge clk);
    base = acks;
    req_tx = 1'b1;
    @(negedge clk); req_tx = 1'b0;
    wait_ack("fresh", 40);
    chk_bytes("fresh", NH, {64'h4341464546303044, 16'h0D0A});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
